mdio_responder: RTL and testbench
=================================

Name: mdio_responder

Overview:
- PHY-side MDIO (IEEE 802.3 Clause 22) responder: oversamples MDC/MDIO with the 125 MHz system clock, decodes management frames addressed to PHY_ADDR, and serves them from a 32x16 register port.
- Sits opposite the existing MDIO master in loopback test builds and in the board-level PHY model, and lets a second FPGA emulate a PHY's management plane.

Parameters:
- PHY_ADDR, 5'b00100, PHY address this responder answers to.
- PREAMBLE_LEN, 32, number of consecutive sampled '1' bits required before ST; legal range 1..63.

Ports:
- clk  input  1  system clock, 125 MHz.
- rst_n  input  1  asynchronous active-low reset.
- mdc  input  1  MDIO clock from the master, at most 2.5 MHz, asynchronous to clk.
- mdio_i  input  1  MDIO pad input.
- mdio_o  output  1  MDIO pad output data.
- mdio_t  output  1  MDIO tristate control; 1 = released (high-Z).
- reg_addr  output  5  register address of the current frame.
- reg_rd  output  1  one-clk read strobe.
- reg_rdata  input  16  read data; must be valid on the clk after reg_rd.
- reg_wr  output  1  one-clk write strobe.
- reg_wdata  output  16  write data, valid while reg_wr is high.
- busy  output  1  high from ST detection until the frame ends or is aborted.
- frame_err  output  1  one-clk pulse on a malformed frame.

Behaviour:
- Reset values: mdio_o=1, mdio_t=1, reg_addr=0, reg_rd=0, reg_wr=0, reg_wdata=0, busy=0, frame_err=0, state=IDLE, preamble count=0.
- Synchronisation and sampling:
  - mdc and mdio_i each pass through 2-flop synchronisers.
  - rise = mdc_s & ~mdc_s_d.
  - Every protocol bit is mdio_s sampled on a rise cycle.
  - All outputs are registered and change only on the clk after a rise.
  - This keeps the delay from the physical MDC edge to the pad within 4 clks (32 ns), far below the 300 ns limit.
- Preamble count: saturating 6-bit count of consecutive sampled 1s; reset to 0 on any sampled 0 while in IDLE.
- State machine (each transition happens on a rise):
  - IDLE: a sampled 0 with preamble count >= PREAMBLE_LEN -> ST2, busy=1. A sampled 0 below the threshold stays in IDLE.
  - ST2: sampled 1 -> OP. Sampled 0 -> IDLE with frame_err.
  - OP: two bits. 10 = read, 01 = write. 00 or 11 -> IDLE with frame_err.
  - PHYAD: five bits, MSB first.
  - REGAD: five bits, MSB first. On the last bit:
    - PHY address mismatch -> SKIP.
    - Otherwise reg_addr is latched; for a read, reg_rd pulses on the following clk.
  - TA, read: the first TA bit period keeps mdio_t=1. On the rise ending TA1, drive mdio_t=0, mdio_o=0. reg_rdata is captured into the shift register on the clk after reg_rd.
  - TA, write: two sampled bits must be 10, else IDLE with frame_err and no reg_wr.
  - RDATA: on each rise, mdio_o shifts out the next bit, MSB first, 16 bits. On the rise ending D0, set mdio_t=1, mdio_o=1 -> IDLE.
  - WDATA: shift in 16 bits. On the rise sampling D0, reg_wdata is loaded and reg_wr pulses on the next clk -> IDLE.
  - SKIP: count 18 further rises (TA + data), never drive the pad -> IDLE.
- After any frame end or abort, preamble count restarts from 0. Back-to-back frames therefore each need a full preamble unless the optional feature is compiled in.
- Asserting rst_n low mid-frame releases the pad immediately, since reset is asynchronous. No reg_wr is issued for a partial frame.
- busy deasserts on the same clk that the state returns to IDLE.
- reg_rd and reg_wr are never both high in the same cycle, and at most one of them is issued per frame.

Optional Feature:
- MDIO_PRE_SUPPRESS_EN defined: preamble suppression is accepted. In IDLE, a single sampled 1 followed by 0 is enough to enter ST2, so PREAMBLE_LEN is ignored after the first complete frame. The very first frame after reset still needs PREAMBLE_LEN ones.
- Not defined: PREAMBLE_LEN ones are required before every frame.

Test Plan:
- Write, PHYAD=4, REGAD=0x1F, data 0xA5C3, 32-bit preamble -> exactly one reg_wr; reg_addr=0x1F, reg_wdata=0xA5C3; mdio_t stays 1 throughout.
- Read, PHYAD=4, REGAD=0x02, reg_rdata=0x1234 -> one reg_rd pulse with reg_addr=0x02. The master samples TA2=0 and data 0x1234 MSB first, and mdio_t returns to 1 after D0.
- Read to PHYAD=5 -> no reg_rd; mdio_t=1 for the whole frame; busy falls after 18 SKIP bits; the next valid frame is decoded normally.
- Preamble of 31 ones, then a valid write -> ignored, no reg_wr. Repeat with 32 ones -> accepted.
- OP=11, and separately a write with TA=00 -> one frame_err pulse each, no strobes; the next valid frame succeeds.
- rst_n pulsed low during RDATA bit 8 -> mdio_t=1 within the same clk. After release plus a full preamble, a read of 0xBEEF completes correctly. With MDIO_PRE_SUPPRESS_EN, two back-to-back writes separated by one idle bit both issue reg_wr.

Source files
------------

// File: rtl/mdio_responder.sv
// PHY-side MDIO (Clause 22) responder: oversamples MDC/MDIO on clk and serves frames from a 32x16 register port.
// Optional build macro MDIO_PRE_SUPPRESS_EN accepts preamble-suppressed frames after the first complete frame.
module mdio_responder #(
    parameter logic [4:0] PHY_ADDR     = 5'b00100,
    parameter int         PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    output logic [4:0]  reg_addr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        reg_wr,
    output logic [15:0] reg_wdata,
    output logic        busy,
    output logic        frame_err
);

    typedef enum logic [3:0] {
        IDLE, ST2, OP, PHYAD, REGAD, TA, RDATA, WDATA, SKIP
    } state_e;

    localparam logic [5:0] PRE_LEN = 6'(PREAMBLE_LEN);

    state_e      state_q, state_d;
    logic [1:0]  mdcSync_q, mdioSync_q;
    logic        mdcPrev_q;
    logic        rise, mdioBit, preOk;
    logic [5:0]  preCnt_q, preCnt_d;
    logic [4:0]  bitCnt_q, bitCnt_d;
    logic        isRead_q, isRead_d;
    logic        firstBit_q, firstBit_d;
    logic [4:0]  phyAd_q, phyAd_d;
    logic [4:0]  regAd_q, regAd_d;
    logic [15:0] shift_q, shift_d;
    logic        rdCap_q;
    logic        mdioO_q, mdioO_d;
    logic        mdioT_q, mdioT_d;
    logic [4:0]  regAddr_q, regAddr_d;
    logic        regRd_q, regRd_d;
    logic        regWr_q, regWr_d;
    logic [15:0] regWdata_q, regWdata_d;
    logic        busy_q;
    logic        frameErr_q, frameErr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdcSync_q  <= 2'b00;
            mdioSync_q <= 2'b11;
            mdcPrev_q  <= 1'b0;
        end else begin
            mdcSync_q  <= {mdcSync_q[0], mdc};
            mdioSync_q <= {mdioSync_q[0], mdio_i};
            mdcPrev_q  <= mdcSync_q[1];
        end
    end

    assign rise    = mdcSync_q[1] & ~mdcPrev_q;
    assign mdioBit = mdioSync_q[1];

`ifdef MDIO_PRE_SUPPRESS_EN
    logic sawFrame_q;

    // Any frame that runs to its natural end unlocks preamble suppression.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sawFrame_q <= 1'b0;
        end else if (rise && state_d == IDLE &&
                     (state_q == RDATA || state_q == WDATA || state_q == SKIP)) begin
            sawFrame_q <= 1'b1;
        end
    end

    assign preOk = (preCnt_q >= PRE_LEN) || (sawFrame_q && preCnt_q != 6'd0);
`else
    assign preOk = (preCnt_q >= PRE_LEN);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            preCnt_q   <= '0;
            bitCnt_q   <= '0;
            isRead_q   <= 1'b0;
            firstBit_q <= 1'b0;
            phyAd_q    <= '0;
            regAd_q    <= '0;
            shift_q    <= '0;
            rdCap_q    <= 1'b0;
            mdioO_q    <= 1'b1;
            mdioT_q    <= 1'b1;
            regAddr_q  <= '0;
            regRd_q    <= 1'b0;
            regWr_q    <= 1'b0;
            regWdata_q <= '0;
            busy_q     <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            preCnt_q   <= preCnt_d;
            bitCnt_q   <= bitCnt_d;
            isRead_q   <= isRead_d;
            firstBit_q <= firstBit_d;
            phyAd_q    <= phyAd_d;
            regAd_q    <= regAd_d;
            shift_q    <= shift_d;
            rdCap_q    <= regRd_q;
            mdioO_q    <= mdioO_d;
            mdioT_q    <= mdioT_d;
            regAddr_q  <= regAddr_d;
            regRd_q    <= regRd_d;
            regWr_q    <= regWr_d;
            regWdata_q <= regWdata_d;
            busy_q     <= (state_d != IDLE);
            frameErr_q <= frameErr_d;
        end
    end

    // Read data is taken one clk after the strobe; the TA2 rise is always many clks later.
    always_comb begin
        state_d    = state_q;
        preCnt_d   = preCnt_q;
        bitCnt_d   = bitCnt_q;
        isRead_d   = isRead_q;
        firstBit_d = firstBit_q;
        phyAd_d    = phyAd_q;
        regAd_d    = regAd_q;
        shift_d    = rdCap_q ? reg_rdata : shift_q;
        mdioO_d    = mdioO_q;
        mdioT_d    = mdioT_q;
        regAddr_d  = regAddr_q;
        regRd_d    = 1'b0;
        regWr_d    = 1'b0;
        regWdata_d = regWdata_q;
        frameErr_d = 1'b0;

        if (rise) begin
            case (state_q)
                IDLE: begin
                    if (mdioBit) begin
                        if (preCnt_q != 6'h3F) preCnt_d = preCnt_q + 6'd1;
                    end else begin
                        preCnt_d = '0;
                        if (preOk) state_d = ST2;
                    end
                end
                ST2: begin
                    bitCnt_d = '0;
                    if (mdioBit) begin
                        state_d = OP;
                    end else begin
                        state_d    = IDLE;
                        frameErr_d = 1'b1;
                    end
                end
                OP: begin
                    if (bitCnt_q == 5'd0) begin
                        firstBit_d = mdioBit;
                        bitCnt_d   = 5'd1;
                    end else begin
                        bitCnt_d = '0;
                        if (firstBit_q != mdioBit) begin
                            isRead_d = firstBit_q;
                            state_d  = PHYAD;
                        end else begin
                            state_d    = IDLE;
                            frameErr_d = 1'b1;
                        end
                    end
                end
                PHYAD: begin
                    phyAd_d = {phyAd_q[3:0], mdioBit};
                    if (bitCnt_q == 5'd4) begin
                        bitCnt_d = '0;
                        state_d  = REGAD;
                    end else begin
                        bitCnt_d = bitCnt_q + 5'd1;
                    end
                end
                REGAD: begin
                    regAd_d = {regAd_q[3:0], mdioBit};
                    if (bitCnt_q == 5'd4) begin
                        bitCnt_d = '0;
                        if (phyAd_q != PHY_ADDR) begin
                            state_d = SKIP;
                        end else begin
                            regAddr_d = {regAd_q[3:0], mdioBit};
                            regRd_d   = isRead_q;
                            state_d   = TA;
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + 5'd1;
                    end
                end
                TA: begin
                    if (bitCnt_q == 5'd0) begin
                        bitCnt_d   = 5'd1;
                        firstBit_d = mdioBit;
                        if (isRead_q) begin
                            mdioT_d = 1'b0;
                            mdioO_d = 1'b0;
                        end
                    end else begin
                        bitCnt_d = '0;
                        if (isRead_q) begin
                            mdioO_d = shift_q[15];
                            shift_d = {shift_q[14:0], 1'b0};
                            state_d = RDATA;
                        end else if (firstBit_q && !mdioBit) begin
                            state_d = WDATA;
                        end else begin
                            state_d    = IDLE;
                            frameErr_d = 1'b1;
                        end
                    end
                end
                RDATA: begin
                    if (bitCnt_q == 5'd15) begin
                        mdioT_d = 1'b1;
                        mdioO_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        mdioO_d  = shift_q[15];
                        shift_d  = {shift_q[14:0], 1'b0};
                        bitCnt_d = bitCnt_q + 5'd1;
                    end
                end
                WDATA: begin
                    shift_d = {shift_q[14:0], mdioBit};
                    if (bitCnt_q == 5'd15) begin
                        regWdata_d = {shift_q[14:0], mdioBit};
                        regWr_d    = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        bitCnt_d = bitCnt_q + 5'd1;
                    end
                end
                SKIP: begin
                    if (bitCnt_q == 5'd17) begin
                        state_d = IDLE;
                    end else begin
                        bitCnt_d = bitCnt_q + 5'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign mdio_o    = mdioO_q;
    assign mdio_t    = mdioT_q;
    assign reg_addr  = regAddr_q;
    assign reg_rd    = regRd_q;
    assign reg_wr    = regWr_q;
    assign reg_wdata = regWdata_q;
    assign busy      = busy_q;
    assign frame_err = frameErr_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Scoreboarded bench for mdio_responder: an MDIO master drives frames, a monitor checks strobes against a queue.
// Build with MDIO_PRE_SUPPRESS_EN defined to exercise preamble suppression.
module tb_mdio_responder;

    localparam logic [4:0] PHY_ADDR     = 5'b00100;
    localparam int         PREAMBLE_LEN = 32;
    localparam int         MDC_HALF     = 25;
`ifdef MDIO_PRE_SUPPRESS_EN
    localparam bit SUPPRESS = 1'b1;
`else
    localparam bit SUPPRESS = 1'b0;
`endif

    localparam int EV_NONE = 0;
    localparam int EV_RD   = 1;
    localparam int EV_WR   = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int          kind;
        logic [4:0]  addr;
        logic [15:0] data;
    } expEv_t;

    logic        clk;
    logic        rst_n;
    logic        mdc;
    logic        mdioM;
    logic        mdioLine;
    logic        mdio_o;
    logic        mdio_t;
    logic [4:0]  reg_addr;
    logic        reg_rd;
    logic [15:0] reg_rdata;
    logic        reg_wr;
    logic [15:0] reg_wdata;
    logic        busy;
    logic        frame_err;

    logic [15:0] regFile [32];
    expEv_t      expQ [$];
    bit          modelSaw;
    int          tests;
    int          failures;

    mdio_responder #(
        .PHY_ADDR     (PHY_ADDR),
        .PREAMBLE_LEN (PREAMBLE_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mdc       (mdc),
        .mdio_i    (mdioLine),
        .mdio_o    (mdio_o),
        .mdio_t    (mdio_t),
        .reg_addr  (reg_addr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .busy      (busy),
        .frame_err (frame_err)
    );

    // Shared pad: the master's drive (or pull-up) wins only while the responder is released.
    assign mdioLine = mdio_t ? mdioM : mdio_o;

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Register file behind the port answers one clk after the read strobe.
    always @(posedge clk) begin
        if (reg_rd) reg_rdata <= regFile[reg_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every strobe or error pulse must match the next queued expectation.
    always @(negedge clk) begin
        int     evKind;
        expEv_t ev;
        if (rst_n && (reg_rd || reg_wr || frame_err)) begin
            evKind = reg_wr ? EV_WR : (reg_rd ? EV_RD : EV_ERR);
            checkOutput("strobe_exclusive", {31'b0, reg_rd & reg_wr}, 32'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_event", evKind, EV_NONE);
            end else begin
                ev = expQ.pop_front();
                checkOutput("event_kind", evKind, ev.kind);
                if (ev.kind != EV_ERR) checkOutput("event_addr", {27'b0, reg_addr}, {27'b0, ev.addr});
                if (ev.kind == EV_WR) checkOutput("event_wdata", {16'b0, reg_wdata}, {16'b0, ev.data});
            end
        end
    end

    task automatic sendBit(input logic b, output logic lineS, output logic tS, output logic busyS);
        mdioM = b;
        repeat (MDC_HALF) @(negedge clk);
        mdc   = 1'b1;
        lineS = mdioLine;
        tS    = mdio_t;
        busyS = busy;
        repeat (MDC_HALF) @(negedge clk);
        mdc = 1'b0;
    endtask

    // One master frame; expectations come from the protocol rules, not from the responder's internals.
    task automatic applyStimulus(input int preLen, input bit leadZero, input logic [1:0] op,
                                 input logic [4:0] phy, input logic [4:0] regA, input logic [1:0] ta,
                                 input logic [15:0] data, input int abortAt);
        bit          accepted, valid, match, isRd, taOk, respond, abortFrame;
        logic        l, t, bz, sawDrive, busyDrop, ta2;
        logic [15:0] got;
        accepted = (preLen >= PREAMBLE_LEN) || (SUPPRESS && modelSaw && preLen >= 1);
        valid    = (op == 2'b10) || (op == 2'b01);
        isRd     = (op == 2'b10);
        match    = (phy == PHY_ADDR);
        taOk     = isRd || (ta == 2'b10);
        respond  = accepted && valid && match && isRd;
        abortFrame = !valid || (match && !taOk);
        if (accepted) begin
            if (abortFrame) expQ.push_back('{EV_ERR, 5'd0, 16'd0});
            else if (match && isRd) expQ.push_back('{EV_RD, regA, 16'd0});
            else if (match) expQ.push_back('{EV_WR, regA, data});
            if (!abortFrame) modelSaw = 1'b1;
        end
        sawDrive = 1'b0;
        busyDrop = 1'b0;
        ta2      = 1'b1;
        got      = '0;
        if (leadZero) begin
            sendBit(1'b0, l, t, bz);
            sawDrive |= !t;
        end
        repeat (preLen) begin
            sendBit(1'b1, l, t, bz);
            sawDrive |= !t;
        end
        sendBit(1'b0, l, t, bz); sawDrive |= !t;
        sendBit(1'b1, l, t, bz); sawDrive |= !t;
        for (int i = 1; i >= 0; i--) begin
            sendBit(op[i], l, t, bz);
            sawDrive |= !t;
        end
        if (valid) begin
            for (int i = 4; i >= 0; i--) begin
                sendBit(phy[i], l, t, bz);
                sawDrive |= !t;
            end
            for (int i = 4; i >= 0; i--) begin
                sendBit(regA[i], l, t, bz);
                sawDrive |= !t;
            end
            if (isRd) begin
                for (int i = 0; i < 18; i++) begin
                    sendBit(1'b1, l, t, bz);
                    if (accepted && !bz) busyDrop = 1'b1;
                    if (!t && (!respond || i == 0)) sawDrive = 1'b1;
                    if (i == 1) ta2 = l;
                    if (i >= 2) got = {got[14:0], l};
                    if (abortAt >= 0 && i == abortAt + 1) begin
                        checkOutput("abort_driving", {31'b0, mdio_t}, 32'd0);
                        checkOutput("abort_partial_rdata", {24'b0, got[7:0]}, {24'b0, regFile[regA][15:8]});
                        rst_n = 1'b0;
                        #1;
                        checkOutput("abort_mdio_t", {31'b0, mdio_t}, 32'd1);
                        checkOutput("abort_mdio_o", {31'b0, mdio_o}, 32'd1);
                        repeat (3) @(negedge clk);
                        rst_n    = 1'b1;
                        modelSaw = 1'b0;
                        mdioM    = 1'b1;
                        repeat (3) @(negedge clk);
                        return;
                    end
                end
                if (respond) begin
                    checkOutput("read_ta2", {31'b0, ta2}, 32'd0);
                    checkOutput("read_data", {16'b0, got}, {16'b0, regFile[regA]});
                end
                if (accepted) checkOutput("busy_through_data", {31'b0, busyDrop}, 32'd0);
            end else begin
                sendBit(ta[1], l, t, bz); sawDrive |= !t;
                sendBit(ta[0], l, t, bz); sawDrive |= !t;
                if (!(match && !taOk)) begin
                    for (int i = 15; i >= 0; i--) begin
                        sendBit(data[i], l, t, bz);
                        sawDrive |= !t;
                    end
                end
            end
        end
        mdioM = 1'b1;
        checkOutput("pad_never_driven", {31'b0, sawDrive}, 32'd0);
        checkOutput("busy_after_frame", {31'b0, busy}, 32'd0);
        checkOutput("mdio_t_after_frame", {31'b0, mdio_t}, 32'd1);
    endtask

    initial begin
        int          r;
        logic [1:0]  rop, rta;
        logic [4:0]  rphy;
        tests    = 0;
        failures = 0;
        modelSaw = 1'b0;
        rst_n    = 1'b0;
        mdc      = 1'b0;
        mdioM    = 1'b1;
        for (int i = 0; i < 32; i++) regFile[i] = 16'($urandom);
        regFile[2]  = 16'h1234;
        regFile[10] = 16'hBEEF;
        repeat (4) @(negedge clk);
        checkOutput("reset_mdio_o", {31'b0, mdio_o}, 32'd1);
        checkOutput("reset_mdio_t", {31'b0, mdio_t}, 32'd1);
        checkOutput("reset_reg_addr", {27'b0, reg_addr}, 32'd0);
        checkOutput("reset_reg_rd", {31'b0, reg_rd}, 32'd0);
        checkOutput("reset_reg_wr", {31'b0, reg_wr}, 32'd0);
        checkOutput("reset_reg_wdata", {16'b0, reg_wdata}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_frame_err", {31'b0, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        applyStimulus(32, 1'b1, 2'b01, PHY_ADDR, 5'h1F, 2'b10, 16'hA5C3, -1);
        applyStimulus(32, 1'b1, 2'b10, PHY_ADDR, 5'h02, 2'b10, 16'h0000, -1);
        applyStimulus(32, 1'b1, 2'b10, 5'd5,     5'h02, 2'b10, 16'h0000, -1);
        applyStimulus(32, 1'b1, 2'b01, PHY_ADDR, 5'h03, 2'b10, 16'h5A5A, -1);
        applyStimulus(31, 1'b1, 2'b01, PHY_ADDR, 5'h04, 2'b10, 16'h1111, -1);
        applyStimulus(32, 1'b1, 2'b01, PHY_ADDR, 5'h04, 2'b10, 16'h2222, -1);
        applyStimulus(32, 1'b1, 2'b11, PHY_ADDR, 5'h05, 2'b10, 16'h3333, -1);
        applyStimulus(32, 1'b1, 2'b01, PHY_ADDR, 5'h06, 2'b00, 16'h4444, -1);
        applyStimulus(32, 1'b1, 2'b01, PHY_ADDR, 5'h07, 2'b10, 16'h5555, -1);
        applyStimulus(32, 1'b1, 2'b10, PHY_ADDR, 5'h0A, 2'b10, 16'h0000, 8);
        applyStimulus(32, 1'b1, 2'b10, PHY_ADDR, 5'h0A, 2'b10, 16'h0000, -1);
`ifdef MDIO_PRE_SUPPRESS_EN
        applyStimulus(32, 1'b1, 2'b01, PHY_ADDR, 5'h08, 2'b10, 16'h6789, -1);
        applyStimulus(1,  1'b0, 2'b01, PHY_ADDR, 5'h09, 2'b10, 16'h9876, -1);
`endif
        for (int n = 0; n < 6; n++) begin
            r    = $urandom_range(0, 9);
            rop  = (r < 4) ? 2'b10 : ((r < 8) ? 2'b01 : ((r == 8) ? 2'b00 : 2'b11));
            rphy = ($urandom_range(0, 3) == 0) ? 5'($urandom) : PHY_ADDR;
            rta  = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b10;
            applyStimulus($urandom_range(30, 34), 1'b1, rop, rphy, 5'($urandom), rta, 16'($urandom), -1);
        end

        repeat (20) @(negedge clk);
        checkOutput("events_outstanding", expQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
